ac_store_unit: RTL and testbench

AC_STORE_UNIT -- requirements
Module: ac_store_unit

---
 rtl/ac_store_unit_pkg.sv | 19 +
 rtl/store_fifo.sv | 62 ++++++
 rtl/ac_store_unit.sv | 139 +++++++++++++
 tb/tb_ac_store_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ac_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ac_store_unit_pkg
// Description : Shared processor definitions for the accumulator store path.
// Revision    : 1.0 - initial release
// ============================================================================
package ac_store_unit_pkg;

    localparam int c_data_w = 16;
    localparam int c_addr_w = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } store_state_e;

endpackage
`default_nettype wire

// File: rtl/store_fifo.sv
`default_nettype none
// ============================================================================
// Module      : store_fifo
// Description : Power-of-two depth FIFO; a pop frees a slot for a same-cycle push.
// Revision    : 1.0 - initial release
// ============================================================================
module store_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] c_depth = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = i_pop & (r_count != '0);
    assign w_do_push = i_push & ((r_count != c_depth) | w_do_pop);

    // Pointers wrap on their own because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == c_depth);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/ac_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : ac_store_unit
// Description : Queues accumulator stores and drains them to memory with timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module ac_store_unit
    import ac_store_unit_pkg::*;
#(
    parameter int DATA_W  = c_data_w,
    parameter int ADDR_W  = c_addr_w,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              store_req,
    input  logic [ADDR_W-1:0] store_addr,
    input  logic [DATA_W-1:0] ac_data,
    output logic              full,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              done,
    output logic              overflow,
    output logic              timeout_err,
    input  logic              clear_err
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT - 1);

    store_state_e              r_state;
    store_state_e              w_state_next;
    logic [WAIT_W-1:0]         r_wait;
    logic [ADDR_W-1:0]         r_mem_addr;
    logic [DATA_W-1:0]         r_mem_wdata;
    logic                      r_overflow;
    logic                      r_timeout_err;
    logic                      w_load;
    logic                      w_pop;
    logic                      w_abort;
    logic                      w_drop;
    logic                      w_mem_we;
    logic                      w_done;
    logic                      w_full;
    logic                      w_empty;
    logic [$clog2(DEPTH):0]    w_count;
    logic [ADDR_W+DATA_W-1:0]  w_head;

    store_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (store_req),
        .i_pop   (w_pop),
        .i_wdata ({store_addr, ac_data}),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // A pop in the same cycle makes room, so only an unrelieved full drops.
    assign w_drop = store_req & w_full & ~w_pop;

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_pop        = 1'b0;
        w_abort      = 1'b0;
        w_mem_we     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_load       = 1'b1;
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                w_mem_we = 1'b1;
                if (mem_ready) begin
                    w_pop        = 1'b1;
                    w_state_next = DONE;
                end else if (r_wait == c_wait_last) begin
                    w_pop        = 1'b1;
                    w_abort      = 1'b1;
                    w_state_next = IDLE;
                end
            end
            DONE: begin
                w_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_wait        <= '0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_wait      <= '0;
                r_mem_addr  <= w_head[ADDR_W+DATA_W-1:DATA_W];
                r_mem_wdata <= w_head[DATA_W-1:0];
            end else if (r_state == WRITE && !mem_ready) begin
                r_wait <= r_wait + 1'b1;
            end
            // Error events take priority over a same-cycle clear.
            if (w_drop)         r_overflow <= 1'b1;
            else if (clear_err) r_overflow <= 1'b0;
            if (w_abort)        r_timeout_err <= 1'b1;
            else if (clear_err) r_timeout_err <= 1'b0;
        end
    end

    assign full        = w_full;
    assign busy        = (w_count != '0) | (r_state != IDLE);
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign mem_we      = w_mem_we;
    assign done        = w_done;
    assign overflow    = r_overflow;
    assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_ac_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ac_store_unit
// Description : Scoreboard bench for ac_store_unit with directed store scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ac_store_unit;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic              clock = 1'b0;
    logic              reset;
    logic              store_req;
    logic [ADDR_W-1:0] store_addr;
    logic [DATA_W-1:0] ac_data;
    logic              full;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_ready;
    logic              done;
    logic              overflow;
    logic              timeout_err;
    logic              clear_err;

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          wait_cnt = 0;
    logic        acc_prev = 1'b0;
    logic [31:0] exp_q [$];

    ac_store_unit #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .store_req   (store_req),
        .store_addr  (store_addr),
        .ac_data     (ac_data),
        .full        (full),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_ready   (mem_ready),
        .done        (done),
        .overflow    (overflow),
        .timeout_err (timeout_err),
        .clear_err   (clear_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input logic [15:0] a, input logic [15:0] d, input bit accepted);
        store_req  = 1'b1;
        store_addr = a;
        ac_data    = d;
        if (accepted) exp_q.push_back({a, d});
        cyc();
        store_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 60) begin
            cyc();
            k++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    // Monitor: checks every presented write against the queue head and the done pulse.
    always @(negedge clock) begin
        if (reset) begin
            wait_cnt = 0;
            acc_prev = 1'b0;
        end else begin
            if (acc_prev || done) chk("done_pulse", {31'd0, done}, {31'd0, acc_prev});
            acc_prev = mem_we && mem_ready;
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got %h/%h expected no write", mem_addr, mem_wdata);
                end else begin
                    chk(mem_ready ? "write_accept" : "write_hold", {mem_addr, mem_wdata}, exp_q[0]);
                    if (mem_ready) begin
                        void'(exp_q.pop_front());
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                        if (wait_cnt == TIMEOUT) begin
                            void'(exp_q.pop_front());
                            wait_cnt = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        store_req  = 1'b0;
        store_addr = '0;
        ac_data    = '0;
        mem_ready  = 1'b0;
        clear_err  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_flags", {26'd0, full, busy, mem_we, done, overflow, timeout_err}, 32'd0);
        chk("rst_addr_data", {mem_addr, mem_wdata}, 32'd0);
        reset = 1'b0;
        cyc();

        // Single store with an always-ready memory
        mem_ready = 1'b1;
        req(16'h0010, 16'd15, 1'b1);
        chk("t1_we_c1", {31'd0, mem_we}, 32'd0);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        cyc();
        chk("t1_we_c2", {31'd0, mem_we}, 32'd1);
        chk("t1_addr_data", {mem_addr, mem_wdata}, 32'h0010_000F);
        cyc();
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_we_c3", {31'd0, mem_we}, 32'd0);
        cyc();
        chk("t1_idle", {30'd0, busy, done}, 32'd0);

        // Burst into a stalled memory, overflow on the fifth request
        mem_ready = 1'b0;
        req(16'h0020, 16'd10, 1'b1);
        req(16'h0021, 16'd12, 1'b1);
        req(16'h0022, 16'd1,  1'b1);
        req(16'h0023, 16'd20, 1'b1);
        chk("t2_full", {31'd0, full}, 32'd1);
        chk("t2_no_overflow_yet", {31'd0, overflow}, 32'd0);
        req(16'h0024, 16'd99, 1'b0);
        chk("t2_overflow", {31'd0, overflow}, 32'd1);
        chk("t2_full_after_drop", {31'd0, full}, 32'd1);
        mem_ready = 1'b1;
        wait_idle("t2_drain");
        mem_ready = 1'b0;
        chk("t2_overflow_sticky", {31'd0, overflow}, 32'd1);
        clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;
        chk("t2_overflow_clr", {31'd0, overflow}, 32'd0);

        // Slow memory: ready in the fifth write cycle
        req(16'h0030, 16'h1234, 1'b1);
        cyc();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) mem_ready = 1'b1;
            chk("t3_we_held", {31'd0, mem_we}, 32'd1);
            cyc();
        end
        mem_ready = 1'b0;
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_we_off", {31'd0, mem_we}, 32'd0);
        cyc();
        chk("t3_done_once", {31'd0, done}, 32'd0);

        // Timeout on the first entry, second entry proceeds
        req(16'h0040, 16'hAAAA, 1'b1);
        req(16'h0041, 16'hBBBB, 1'b1);
        repeat (14) cyc();
        chk("t4_no_err_yet", {30'd0, timeout_err, mem_we}, 32'd1);
        cyc();
        chk("t4_timeout_err", {31'd0, timeout_err}, 32'd1);
        chk("t4_we_abort", {30'd0, mem_we, done}, 32'd0);
        cyc();
        chk("t4_next_entry", {mem_addr, mem_wdata}, 32'h0041_BBBB);
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        chk("t4_err_sticky", {31'd0, timeout_err}, 32'd1);
        clear_err = 1'b1;
        cyc();
        clear_err = 1'b0;
        chk("t4_err_clr", {31'd0, timeout_err}, 32'd0);
        wait_idle("t4_drain");

        // Full queue with a same-cycle pop and push
        req(16'h0050, 16'h0051, 1'b1);
        req(16'h0051, 16'h0052, 1'b1);
        req(16'h0052, 16'h0053, 1'b1);
        req(16'h0053, 16'h0054, 1'b1);
        chk("t5_full", {31'd0, full}, 32'd1);
        mem_ready = 1'b1;
        req(16'h0054, 16'h0055, 1'b1);
        chk("t5_no_overflow", {31'd0, overflow}, 32'd0);
        chk("t5_full_kept", {31'd0, full}, 32'd1);
        wait_idle("t5_drain");
        mem_ready = 1'b0;

        // Reset in the middle of a write with entries queued
        req(16'h0060, 16'h0601, 1'b1);
        req(16'h0061, 16'h0602, 1'b1);
        req(16'h0062, 16'h0603, 1'b1);
        chk("t6_we_before", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("t6_rst_flags", {26'd0, full, busy, mem_we, done, overflow, timeout_err}, 32'd0);
        chk("t6_rst_addr_data", {mem_addr, mem_wdata}, 32'd0);
        cyc();
        reset     = 1'b0;
        mem_ready = 1'b1;
        repeat (8) cyc();
        chk("t6_idle_after", {29'd0, busy, mem_we, done}, 32'd0);
        mem_ready = 1'b0;

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
